// File: rtl/prog_minterm_lut.sv
// Programmable N-input boolean function: y = mask[x] (optionally inverted), mask reloaded serially.
// Latency: evaluation is 1 cycle (en at edge N -> y/y_valid after edge N); a load commits one cycle after its last bit.
// Backpressure: none; load and evaluation run concurrently, a load stalls only on ld_valid=0 and never times out.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   en, x, inv          evaluate strobe, minterm index (MSB first), complement select
//   y, y_valid          registered function value and its one-cycle-per-en valid flag
//   ld_start            begin or restart a mask load
//   ld_valid, ld_bit    serial mask bit stream, minterm 0 first
//   ld_busy, ld_done    load in progress, one-cycle pulse when the new mask is committed

module prog_minterm_lut #(
  parameter int                     N_IN       = 4,
  parameter logic [(1<<N_IN)-1:0]   RESET_MASK = 16'h28AC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_IN-1:0] x,
  input  logic            inv,
  output logic            y,
  output logic            y_valid,
  input  logic            ld_start,
  input  logic            ld_valid,
  input  logic            ld_bit,
  output logic            ld_busy,
  output logic            ld_done
);

  localparam int DEPTH = 1 << N_IN;
  // One extra bit so the count can reach DEPTH itself (matters for N_IN=8).
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } ld_state_t;

  ld_state_t          state;
  logic [DEPTH-1:0]   active_mask;
  logic [DEPTH-1:0]   shadow;
  logic [CW-1:0]      cnt;

  // Evaluation path: reads active_mask before this edge, so an en in the
  // COMMIT cycle still sees the old table.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
      if (en) begin
        y <= active_mask[x] ^ inv;
      end
    end
  end

  // Load FSM. Bits accumulate in the shadow register; active_mask is only
  // replaced as a whole in COMMIT, so evaluation never sees a partial table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_mask <= RESET_MASK;
      shadow      <= '0;
      cnt         <= '0;
      ld_busy     <= 1'b0;
      ld_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ld_done <= 1'b0;
          // ld_valid in the start cycle is deliberately dropped.
          if (ld_start) begin
            state   <= SHIFT;
            cnt     <= '0;
            ld_busy <= 1'b1;
          end else begin
            ld_busy <= 1'b0;
          end
        end

        SHIFT: begin
          ld_busy <= 1'b1;
          ld_done <= 1'b0;
          if (ld_start) begin
            // Restart wins over a same-cycle data bit.
            cnt <= '0;
          end else if (ld_valid) begin
            shadow[cnt[CW-2:0]] <= ld_bit;
            cnt                 <= cnt + CW'(1);
            if (cnt == CW'(DEPTH - 1)) begin
              state   <= COMMIT;
              ld_done <= 1'b1;
            end
          end
        end

        COMMIT: begin
          // ld_start / ld_valid are ignored for this single cycle.
          active_mask <= shadow;
          state       <= IDLE;
          ld_busy     <= 1'b0;
          ld_done     <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          ld_busy <= 1'b0;
          ld_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_minterm_lut.md
Name: prog_minterm_lut

Overview:
Programmable N-input boolean function evaluator. The function is held as a 2^N_IN-bit minterm mask: bit k set means minterm k is in the sum-of-products. The mask is reloaded at run time through a serial load port, double-buffered so evaluation never sees a partial table. Evaluation is registered with a valid flag, and the block carries an optional complement mode (POS view). It replaces hard-wired decoder-plus-OR function blocks in the lab datapath.

Parameters:
N_IN, 4, number of function inputs; legal 1..8.
DEPTH, 1<<N_IN, mask width / number of minterms; derived, do not override.
RESET_MASK, 16'h28AC, active mask after reset (minterms 2,3,5,7,11,13); width DEPTH.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  evaluate strobe
x  input  N_IN  minterm index, x[N_IN-1] is MSB (x[3]=a ... x[0]=d for N_IN=4)
inv  input  1  0: y = mask[x]; 1: y = ~mask[x]
y  output  1  registered function value
y_valid  output  1  high for exactly the cycles following an en cycle
ld_start  input  1  begin (or restart) a mask load
ld_valid  input  1  ld_bit is valid this cycle
ld_bit  input  1  serial mask bit, minterm 0 first (LSB-first)
ld_busy  output  1  load in progress
ld_done  output  1  one-cycle pulse, new mask committed

Behaviour:
- Reset (rst=1 at edge): active_mask=RESET_MASK, shadow=0, bit counter=0, y=0, y_valid=0, ld_busy=0, ld_done=0. Reset overrides every other input, including a load in progress; the partial load is discarded.
- Evaluation, latency 1:
  - en=1 at edge N: y <= mask[x] XOR inv, using the active_mask value before edge N. y_valid <= 1.
  - en=0: y holds its last value; y_valid <= 0.
  - x is always in range (DEPTH = 2^N_IN), so no out-of-range case exists.
- Load FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: ld_busy=0. ld_start=1 -> SHIFT, counter=0. ld_valid is ignored in IDLE.
  - SHIFT: ld_busy=1. Each ld_valid=1 cycle writes shadow[counter]=ld_bit and increments counter. ld_valid=0 cycles stall with no change, and there is no timeout.
    - The bit that brings counter to DEPTH -> COMMIT.
    - ld_start=1 in SHIFT restarts: counter=0, shadow content is don't-care, and any ld_valid in the same cycle is ignored.
  - COMMIT, one cycle: active_mask <= shadow, ld_done=1, ld_busy=1, then -> IDLE.
    - ld_start in the COMMIT cycle is ignored.
    - ld_valid in the COMMIT cycle is ignored.
- Commit timing: an en evaluated in the COMMIT cycle uses the old mask. The first en cycle after COMMIT uses the new mask.
- Counter is clog2(DEPTH)+1 bits wide, so DEPTH=256 terminates correctly with no wrap.
- ld_start and ld_valid are both allowed in the IDLE->SHIFT cycle, but that ld_valid is ignored. Bit 0 is taken on the next ld_valid.
- Load and evaluation operate concurrently and never stall each other.

Test Plan:
- Reset, then en=1, inv=0 with x=5,4,13,0 on consecutive cycles -> y=1,0,1,0 one cycle later each; y_valid=1 for 4 cycles, then 0.
- Reset, then en=1, x=5, inv=1 -> y=0. Drop en -> y holds 0, y_valid=0.
- Load 16'h8001 (16 ld_valid bits LSB-first, with 3 stall cycles inserted) -> ld_busy high throughout; ld_done pulses once after the 16th bit. Then x=15 -> 1, x=0 -> 1, x=5 -> 0.
- Hold en=1, x=2 across the load COMMIT cycle with new mask 16'h0000 -> y=1 for the COMMIT-cycle evaluation, y=0 for the next.
- Send 7 bits, then ld_start, then a full 16'h00F0 load -> mask=00F0; x=4 -> 1, x=8 -> 0. Exactly one ld_done pulse.
- Send 9 bits, then assert rst -> ld_busy=0, no ld_done pulse, mask=28AC; x=11 -> 1.
